sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 80 ++++++++
 tb/tb_sync_fifo.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Latency: write visible (empty falls) right after the accepting edge; read data
// on dout right after the accepting edge. Backpressure: wr ignored while full,
// rd ignored while empty; upstream only needs to watch the flags.
//
// Ports:
//   clk   - rising-edge clock for all state
//   rst   - asynchronous active-low reset (clears pointers and dout)
//   din   - write data, captured on an accepted write
//   wr    - write request
//   rd    - read request
//   dout  - registered read data, changes only on an accepted read or reset
//   full  - DEPTH entries stored
//   empty - zero entries stored
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage is deliberately not reset; the pointers alone define validity.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the low (index) bits match.
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [DATA_WIDTH-1:0] r_dout;

  logic w_wr_acc;
  logic w_rd_acc;
  logic w_full;
  logic w_empty;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);

  // Accept decisions use the pre-edge flags, so wr&rd while full drops the
  // write and wr&rd while empty drops the read.
  assign w_wr_acc = wr && !w_full;
  assign w_rd_acc = rd && !w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_dout <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rptr[AW-1:0]];
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  assign dout  = r_dout;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: self-checking bench for sync_fifo (DEPTH=16, DATA_WIDTH=8).
// A queue model tracks stored words; every cycle dout/full/empty are compared
// against it, and a vector table adds hand-computed expectations.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          wr  = 1'b0;
  logic          rd  = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wr    (wr),
    .rd    (rd),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] exp_dout = '0;
  int            n_aa_seen = 0;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    logic          exp_full;
    logic          exp_empty;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One clock of stimulus: drive on the falling edge, check 1 ns after rise.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit w_acc;
    bit r_acc;
    @(negedge clk);
    wr  = w;
    rd  = r;
    din = d;
    w_acc = w && (sb_q.size() < DEPTH);
    r_acc = r && (sb_q.size() != 0);
    @(posedge clk);
    #1;
    if (r_acc) begin
      exp_dout = sb_q.pop_front();
      if (exp_dout == 8'hAA) n_aa_seen++;
    end
    if (w_acc) sb_q.push_back(d);
    chk("dout",  dout, exp_dout);
    chk("full",  {7'b0, full},  {7'b0, (sb_q.size() == DEPTH)});
    chk("empty", {7'b0, empty}, {7'b0, (sb_q.size() == 0)});
    wr = 1'b0;
    rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Hand-computed sequence starting from an empty FIFO with dout = 0.
    vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1}; // underflow read
    vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 1'b0}; // wr&rd on empty: write only
    vecs[2] = '{1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h55, 8'h11, 1'b0, 1'b0}; // 3 stored: both accepted
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1}; // 0x55 read last
    vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1}; // underflow holds dout

    // Reset held 5 cycles.
    repeat (5) @(posedge clk);
    #1;
    chk("rst_empty", {7'b0, empty}, 8'h01);
    chk("rst_full",  {7'b0, full},  8'h00);
    chk("rst_dout",  dout,          8'h00);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_empty", {7'b0, empty}, 8'h01);
    chk("post_rst_full",  {7'b0, full},  8'h00);
    chk("post_rst_dout",  dout,          8'h00);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("vec%0d_dout", i),  dout,           vecs[i].exp_dout);
      chk($sformatf("vec%0d_full", i),  {7'b0, full},  {7'b0, vecs[i].exp_full});
      chk($sformatf("vec%0d_empty", i), {7'b0, empty}, {7'b0, vecs[i].exp_empty});
    end

    // Fill with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
    chk("fill_full",  {7'b0, full},  8'h01);
    chk("fill_empty", {7'b0, empty}, 8'h00);

    // Overflow write is dropped.
    step(1'b1, 1'b0, 8'hAA);
    chk("ovf_full", {7'b0, full}, 8'h01);

    // wr&rd while full: read 0x01 accepted, 0x77 dropped, 15 left.
    step(1'b1, 1'b1, 8'h77);
    chk("full_rw_dout", dout,          8'h01);
    chk("full_rw_full", {7'b0, full}, 8'h00);

    // Drain remaining 15: 0x02..0x10, never 0xAA or 0x77.
    for (int i = 2; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("drain_order", dout, 8'(i));
    end
    chk("drain_empty", {7'b0, empty}, 8'h01);
    chk("no_aa_read",  8'(n_aa_seen), 8'h00);

    // Underflow read: dout holds 0x10.
    step(1'b0, 1'b1, 8'h00);
    chk("udf_dout",  dout,           8'h10);
    chk("udf_empty", {7'b0, empty}, 8'h01);

    // Random interleaved traffic across pointer wraps.
    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50), 8'(8'h80 + i));
    end
    while (sb_q.size() > 0) step(1'b0, 1'b1, 8'h00);
    // Bulk traffic to push pointers through several more wraps.
    for (int i = 0; i < 48; i++) begin
      step(1'b1, (i > 3), 8'(8'hD0 + i));
    end

    // Reset mid-operation with 7 entries stored.
    while (sb_q.size() > 0) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_empty", {7'b0, empty}, 8'h01);
    chk("mid_rst_full",  {7'b0, full},  8'h00);
    chk("mid_rst_dout",  dout,          8'h00);
    sb_q.delete();
    exp_dout = '0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'hC1);
    step(1'b0, 1'b1, 8'h00);
    chk("after_rst_new_data", dout,          8'hC1);
    chk("after_rst_empty",    {7'b0, empty}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
